// File: rtl/scpad_tile_reader_if.sv
// Bundle of the tile request, scratchpad read port and row-stream handshakes.
// slave is the tile reader itself; master is whoever feeds and drains it.
interface scpad_tile_reader_if #(
    parameter int NUM_COLS      = 32,
    parameter int ELEM_BITS     = 16,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int MAX_DIM_WIDTH = 5
);
    logic                          req_valid;
    logic                          req_ready;
    logic [ROW_IDX_WIDTH-1:0]      req_base_row;
    logic [MAX_DIM_WIDTH-1:0]      req_rows_m1;
    logic [MAX_DIM_WIDTH-1:0]      req_col_start;
    logic [MAX_DIM_WIDTH-1:0]      req_cols_m1;
    logic                          sram_rd_req;
    logic                          sram_rd_gnt;
    logic [ROW_IDX_WIDTH-1:0]      sram_rd_row;
    logic [NUM_COLS*ELEM_BITS-1:0] sram_rd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_COLS*ELEM_BITS-1:0] out_data;
    logic [NUM_COLS-1:0]           out_mask;
    logic                          out_last;
    logic                          busy;
    logic                          done;

    modport slave (
        input  req_valid, req_base_row, req_rows_m1,
        input  req_col_start, req_cols_m1,
        input  sram_rd_gnt, sram_rd_data, out_ready,
        output req_ready, sram_rd_req, sram_rd_row,
        output out_valid, out_data, out_mask, out_last,
        output busy, done
    );

    modport master (
        output req_valid, req_base_row, req_rows_m1,
        output req_col_start, req_cols_m1,
        output sram_rd_gnt, sram_rd_data, out_ready,
        input  req_ready, sram_rd_req, sram_rd_row,
        input  out_valid, out_data, out_mask, out_last,
        input  busy, done
    );
endinterface

// File: rtl/scpad_tile_reader.sv
// Streams a tile out of a row-wide scratchpad, one row per beat,
// rotating each row so the tile's first column lands in lane 0.
module scpad_tile_reader #(
    parameter int NUM_COLS      = 32,
    parameter int ELEM_BITS     = 16,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int MAX_DIM_WIDTH = 5
) (
    input  logic               CLK,
    input  logic               RST,
    scpad_tile_reader_if.slave bus
);
    localparam int RW = NUM_COLS * ELEM_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                   r_state;
    logic [ROW_IDX_WIDTH-1:0] r_base;
    logic [MAX_DIM_WIDTH-1:0] r_rows_m1;
    logic [MAX_DIM_WIDTH-1:0] r_col_start;
    logic [MAX_DIM_WIDTH-1:0] r_cols_m1;
    logic [MAX_DIM_WIDTH-1:0] r_cnt;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic [RW-1:0]            r_mem [2];
    logic [1:0]               r_tag;
    logic                     r_rd;
    logic                     r_wr;
    logic [1:0]               r_count;

    logic          w_credit;
    logic          w_grant;
    logic          w_empty;
    logic          w_pop;
    logic          w_pop_mem;
    logic          w_push;
    logic [RW-1:0] w_head;
    int            w_src;

    // Stored rows plus the read still in flight may never exceed two.
    assign w_credit  = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;
    assign w_grant   = bus.sram_rd_req && bus.sram_rd_gnt;
    assign w_empty   = (r_count == 2'd0);
    assign w_pop     = bus.out_valid && bus.out_ready;
    assign w_pop_mem = w_pop && !w_empty;
    // Returning data is visible straight away when nothing is queued ahead.
    assign w_push    = r_inflight && !(w_empty && w_pop);
    assign w_head    = w_empty ? bus.sram_rd_data : r_mem[r_rd];

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.sram_rd_req = (r_state == ISSUE) && w_credit;
    assign bus.sram_rd_row = r_base + ROW_IDX_WIDTH'(r_cnt);
    assign bus.out_valid   = !w_empty || r_inflight;
    assign bus.out_last    = w_empty ? r_inflight_last : r_tag[r_rd];
    assign bus.done        = (r_state == DRAIN) && w_empty && !r_inflight;

    always_comb begin
        bus.out_data = '0;
        bus.out_mask = '0;
        w_src        = 0;
        for (int i = 0; i < NUM_COLS; i++) begin
            w_src = (int'(r_col_start) + i) % NUM_COLS;
            bus.out_data[i*ELEM_BITS +: ELEM_BITS] =
                w_head[w_src*ELEM_BITS +: ELEM_BITS];
            bus.out_mask[i] = (i <= int'(r_cols_m1)) &&
                              (int'(r_col_start) + i <= NUM_COLS - 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            r_base          <= '0;
            r_rows_m1       <= '0;
            r_col_start     <= '0;
            r_cols_m1       <= '0;
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_tag           <= '0;
            r_rd            <= 1'b0;
            r_wr            <= 1'b0;
            r_count         <= '0;
        end else begin
            r_inflight      <= w_grant;
            r_inflight_last <= w_grant && (r_cnt == r_rows_m1);
            if (w_push) begin
                r_mem[r_wr] <= bus.sram_rd_data;
                r_tag[r_wr] <= r_inflight_last;
                r_wr        <= !r_wr;
            end
            if (w_pop_mem)
                r_rd <= !r_rd;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_mem};
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_base      <= bus.req_base_row;
                        r_rows_m1   <= bus.req_rows_m1;
                        r_col_start <= bus.req_col_start;
                        r_cols_m1   <= bus.req_cols_m1;
                        r_cnt       <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_grant) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_rows_m1)
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.done)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scpad_tile_reader.sv
// Bench for scpad_tile_reader: scratchpad model plus a row-level reference
// of the expected tile stream built from plain rotate/mask arithmetic.
module tb_scpad_tile_reader;
    localparam int NC    = 32;
    localparam int EB    = 16;
    localparam int RW    = 14;
    localparam int DW    = 5;
    localparam int DBITS = NC * EB;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    scpad_tile_reader_if #(
        .NUM_COLS(NC), .ELEM_BITS(EB),
        .ROW_IDX_WIDTH(RW), .MAX_DIM_WIDTH(DW)
    ) bus ();

    scpad_tile_reader #(
        .NUM_COLS(NC), .ELEM_BITS(EB),
        .ROW_IDX_WIDTH(RW), .MAX_DIM_WIDTH(DW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Row contents: lane number in the top bits, row in the bottom bits.
    function automatic logic [DBITS-1:0] row_word(input logic [RW-1:0] row);
        logic [DBITS-1:0] w;
        w = '0;
        for (int l = 0; l < NC; l++)
            w[l*EB +: EB] = {5'(l), row[10:0]};
        return w;
    endfunction

    function automatic logic [DBITS-1:0] exp_data(int base, int r, int cs);
        logic [DBITS-1:0]   w;
        logic [2*DBITS-1:0] ww;
        w  = row_word(RW'((base + r) % 16384));
        ww = {w, w} >> (cs * EB);
        return ww[DBITS-1:0];
    endfunction

    function automatic logic [NC-1:0] exp_mask(int cs, int cm1);
        longint unsigned a, b;
        a = (64'd1 << (cm1 + 1)) - 64'd1;
        b = (64'd1 << (NC - cs)) - 64'd1;
        return NC'(a & b);
    endfunction

    // Scratchpad: data appears exactly one cycle after a granted read.
    always @(posedge CLK) begin
        if (bus.sram_rd_req && bus.sram_rd_gnt)
            bus.sram_rd_data <= row_word(bus.sram_rd_row);
        else
            bus.sram_rd_data <= {16{$urandom}};
    end

    int               e_rows[$];
    logic [DBITS-1:0] e_data[$];
    logic [NC-1:0]    e_mask[$];
    logic             e_last[$];

    task automatic build_exp(int base, int rm1, int cs, int cm1);
        e_rows.delete(); e_data.delete();
        e_mask.delete(); e_last.delete();
        for (int r = 0; r <= rm1; r++) begin
            e_rows.push_back((base + r) % 16384);
            e_data.push_back(exp_data(base, r, cs));
            e_mask.push_back(exp_mask(cs, cm1));
            e_last.push_back(r == rm1);
        end
    endtask

    int               rd_rows[$];
    int               rd_cyc[$];
    int               out_cyc[$];
    logic [DBITS-1:0] o_data[$];
    logic [NC-1:0]    o_mask[$];
    logic             o_last[$];
    int   done_cyc, wait_cyc, max_out;
    int   full_err, stab_err, row_stab_err, busy_err;
    logic rdy_at_done;

    // Runs one tile and records what the DUT did; called at posedge+1,
    // returns at a negedge. abort_pops > 0 stops after that many rows.
    task automatic run_tile(int base, int rm1, int cs, int cm1,
                            int g_s, int g_n, int r_s, int r_n,
                            bit rnd, int abort_pops);
        int               grants, pops;
        logic             prev_stall, prev_ungr, fin;
        logic [DBITS-1:0] pd;
        logic [NC-1:0]    pm;
        logic             pl;
        logic [RW-1:0]    prow;
        rd_rows.delete(); rd_cyc.delete(); out_cyc.delete();
        o_data.delete(); o_mask.delete(); o_last.delete();
        done_cyc = -1; wait_cyc = 0; max_out = 0;
        full_err = 0; stab_err = 0; row_stab_err = 0; busy_err = 0;
        rdy_at_done = 1'bx;
        grants = 0; pops = 0; fin = 1'b0;
        prev_stall = 1'b0; prev_ungr = 1'b0;
        pd = '0; pm = '0; pl = 1'b0; prow = '0;
        bus.req_base_row  = RW'(base);
        bus.req_rows_m1   = DW'(rm1);
        bus.req_col_start = DW'(cs);
        bus.req_cols_m1   = DW'(cm1);
        bus.req_valid     = 1'b1;
        bus.sram_rd_gnt   = 1'b1;
        bus.out_ready     = 1'b1;
        @(negedge CLK);
        while (bus.req_ready !== 1'b1 && wait_cyc < 50) begin
            @(posedge CLK); #1;
            wait_cyc++;
            @(negedge CLK);
        end
        if (bus.req_ready !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout req_ready=%b want 1", bus.req_ready);
            @(posedge CLK); #1;
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (rnd) begin
                bus.sram_rd_gnt = ($urandom_range(0, 3) != 0);
                bus.out_ready   = ($urandom_range(0, 3) != 0);
            end else begin
                bus.sram_rd_gnt = !(k >= g_s && k < g_s + g_n);
                bus.out_ready   = !(k >= r_s && k < r_s + r_n);
            end
            @(negedge CLK);
            if (bus.busy !== 1'b1) busy_err++;
            if (grants - pops >= 2 && bus.sram_rd_req !== 1'b0) full_err++;
            if (prev_ungr && (bus.sram_rd_req !== 1'b1 ||
                              bus.sram_rd_row !== prow))
                row_stab_err++;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                               bus.out_mask !== pm || bus.out_last !== pl))
                stab_err++;
            prev_ungr  = bus.sram_rd_req && !bus.sram_rd_gnt;
            prow       = bus.sram_rd_row;
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pm = bus.out_mask; pl = bus.out_last;
            if (bus.sram_rd_req && bus.sram_rd_gnt) begin
                rd_rows.push_back(int'(bus.sram_rd_row));
                rd_cyc.push_back(k);
                grants++;
            end
            if (bus.out_valid && bus.out_ready) begin
                o_data.push_back(bus.out_data);
                o_mask.push_back(bus.out_mask);
                o_last.push_back(bus.out_last);
                out_cyc.push_back(k);
                pops++;
            end
            if (grants - pops > max_out) max_out = grants - pops;
            if (bus.done === 1'b1) begin
                done_cyc = k; rdy_at_done = bus.req_ready; fin = 1'b1;
                break;
            end
            if (abort_pops > 0 && pops >= abort_pops) begin
                fin = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout rows=%0d want %0d", pops, rm1 + 1);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        n_chk++;
        if ({bus.req_ready, bus.sram_rd_req, bus.out_valid,
             bus.out_last, bus.busy, bus.done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_held rdy/req/ov/last/busy/done=%b want 100000",
                {bus.req_ready, bus.sram_rd_req, bus.out_valid,
                 bus.out_last, bus.busy, bus.done});
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({bus.req_ready, bus.sram_rd_req, bus.out_valid,
             bus.out_last, bus.busy, bus.done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_release outputs=%b want 100000",
                {bus.req_ready, bus.sram_rd_req, bus.out_valid,
                 bus.out_last, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        build_exp(100, 3, 0, 31);
        run_tile(100, 3, 0, 31, 0, 0, 0, 0, 1'b0, 0);
        n_chk++;
        if (rd_rows.size() != 4 || o_data.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count reads=%0d rows=%0d want 4/4",
                rd_rows.size(), o_data.size());
        end
        for (int r = 0; r < 4 && r < rd_rows.size(); r++) begin
            n_chk++;
            if (rd_rows[r] !== 100 + r || rd_cyc[r] !== r + 1) begin
                n_fail++;
                $display("FAIL basic_read%0d row=%0d cyc=%0d want %0d/%0d",
                    r, rd_rows[r], rd_cyc[r], 100 + r, r + 1);
            end
        end
        for (int r = 0; r < 4 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_mask[r] !== 32'hFFFF_FFFF ||
                o_last[r] !== (r == 3) || out_cyc[r] !== r + 2) begin
                n_fail++;
                $display("FAIL basic_row%0d mask=%h last=%b cyc=%0d data_ok=%0b want mask=ffffffff last=%b cyc=%0d",
                    r, o_mask[r], o_last[r], out_cyc[r],
                    o_data[r] === e_data[r], r == 3, r + 2);
            end
        end
        n_chk++;
        if (done_cyc !== 6 || busy_err !== 0 || rdy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done cyc=%0d busy_err=%0d rdy=%b want 6/0/0",
                done_cyc, busy_err, rdy_at_done);
        end
    endtask

    task automatic test_wrap();
        build_exp(16382, 3, 0, 31);
        run_tile(16382, 3, 0, 31, 0, 0, 0, 0, 1'b0, 0);
        n_chk++;
        if (rd_rows.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count reads=%0d want 4", rd_rows.size());
        end
        for (int r = 0; r < 4 && r < rd_rows.size(); r++) begin
            n_chk++;
            if (rd_rows[r] !== e_rows[r]) begin
                n_fail++;
                $display("FAIL wrap_read%0d row=%0d want %0d",
                    r, rd_rows[r], e_rows[r]);
            end
        end
        for (int r = 0; r < 4 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_last[r] !== e_last[r]) begin
                n_fail++;
                $display("FAIL wrap_row%0d last=%b want %b data_ok=%0b",
                    r, o_last[r], e_last[r], o_data[r] === e_data[r]);
            end
        end
    endtask

    task automatic test_align();
        build_exp(500, 1, 28, 7);
        run_tile(500, 1, 28, 7, 0, 0, 0, 0, 1'b0, 0);
        n_chk++;
        if (o_data.size() != 2) begin
            n_fail++;
            $display("FAIL align_count rows=%0d want 2", o_data.size());
        end
        for (int r = 0; r < 2 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_mask[r] !== 32'h0000_000F) begin
                n_fail++;
                $display("FAIL align_row%0d mask=%h want 0000000f lane0=%h want %h",
                    r, o_mask[r], o_data[r][EB-1:0], e_data[r][EB-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        build_exp(200, 7, 3, 20);
        run_tile(200, 7, 3, 20, 0, 0, 3, 10, 1'b0, 0);
        n_chk++;
        if (o_data.size() != 8 || done_cyc < 0) begin
            n_fail++;
            $display("FAIL bp_count rows=%0d done=%0d want 8 rows and done",
                o_data.size(), done_cyc);
        end
        for (int r = 0; r < 8 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_mask[r] !== e_mask[r] ||
                o_last[r] !== e_last[r]) begin
                n_fail++;
                $display("FAIL bp_row%0d mask=%h/%h last=%b/%b data_ok=%0b",
                    r, o_mask[r], e_mask[r], o_last[r], e_last[r],
                    o_data[r] === e_data[r]);
            end
        end
        n_chk++;
        if (full_err !== 0 || stab_err !== 0 || max_out !== 2) begin
            n_fail++;
            $display("FAIL bp_flow full_err=%0d stab_err=%0d max_buf=%0d want 0/0/2",
                full_err, stab_err, max_out);
        end
    endtask

    task automatic test_gnt_stall();
        build_exp(300, 5, 0, 31);
        run_tile(300, 5, 0, 31, 2, 3, 0, 0, 1'b0, 0);
        n_chk++;
        if (row_stab_err !== 0 || rd_cyc.size() < 2 || rd_cyc[1] !== 5) begin
            n_fail++;
            $display("FAIL gnt_stall row_stab_err=%0d second_read_cyc=%0d want 0/5",
                row_stab_err, rd_cyc.size() > 1 ? rd_cyc[1] : -1);
        end
        for (int r = 0; r < 6 && r < rd_rows.size(); r++) begin
            n_chk++;
            if (rd_rows[r] !== e_rows[r] || o_data.size() <= r ||
                o_data[r] !== e_data[r]) begin
                n_fail++;
                $display("FAIL gnt_row%0d read=%0d want %0d outs=%0d",
                    r, rd_rows[r], e_rows[r], o_data.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic d_seen;
        run_tile(1000, 7, 0, 31, 0, 0, 0, 0, 1'b0, 2);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        d_seen = bus.done;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({bus.req_ready, bus.sram_rd_req, bus.out_valid,
             bus.out_last, bus.busy, bus.done} !== 6'b100000 ||
            d_seen !== 1'b0 || done_cyc !== -1) begin
            n_fail++;
            $display("FAIL rst_mid outputs=%b done_seen=%b/%0d want 100000/0/-1",
                {bus.req_ready, bus.sram_rd_req, bus.out_valid,
                 bus.out_last, bus.busy, bus.done}, d_seen, done_cyc);
        end
        @(posedge CLK); #1;
        build_exp(2000, 3, 5, 10);
        run_tile(2000, 3, 5, 10, 0, 0, 0, 0, 1'b0, 0);
        n_chk++;
        if (o_data.size() != 4 || done_cyc !== 6) begin
            n_fail++;
            $display("FAIL rst_after rows=%0d done=%0d want 4/6",
                o_data.size(), done_cyc);
        end
        for (int r = 0; r < 4 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_mask[r] !== e_mask[r] ||
                o_last[r] !== e_last[r]) begin
                n_fail++;
                $display("FAIL rst_after_row%0d mask=%h/%h last=%b/%b",
                    r, o_mask[r], e_mask[r], o_last[r], e_last[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic first_rdy;
        run_tile(40, 2, 0, 31, 0, 0, 0, 0, 1'b0, 0);
        first_rdy = rdy_at_done;
        @(posedge CLK); #1;
        build_exp(50, 1, 1, 31);
        run_tile(50, 1, 1, 31, 0, 0, 0, 0, 1'b0, 0);
        n_chk++;
        if (first_rdy !== 1'b0 || wait_cyc !== 0) begin
            n_fail++;
            $display("FAIL b2b_accept ready_on_done=%b wait=%0d want 0/0",
                first_rdy, wait_cyc);
        end
        for (int r = 0; r < 2 && r < o_data.size(); r++) begin
            n_chk++;
            if (o_data[r] !== e_data[r] || o_mask[r] !== e_mask[r]) begin
                n_fail++;
                $display("FAIL b2b_row%0d mask=%h want %h", r, o_mask[r], e_mask[r]);
            end
        end
    endtask

    task automatic test_random();
        int base, rm1, cs, cm1;
        for (int t = 0; t < 20; t++) begin
            base = $urandom_range(0, 16383);
            rm1  = $urandom_range(0, 7);
            cs   = $urandom_range(0, 31);
            cm1  = $urandom_range(0, 31);
            build_exp(base, rm1, cs, cm1);
            @(posedge CLK); #1;
            run_tile(base, rm1, cs, cm1, 0, 0, 0, 0, 1'b1, 0);
            n_chk++;
            if (o_data.size() != rm1 + 1 || rd_rows.size() != rm1 + 1 ||
                full_err !== 0 || stab_err !== 0 || row_stab_err !== 0 ||
                max_out > 2) begin
                n_fail++;
                $display("FAIL rnd%0d_flow rows=%0d reads=%0d want %0d full=%0d stab=%0d rstab=%0d buf=%0d",
                    t, o_data.size(), rd_rows.size(), rm1 + 1,
                    full_err, stab_err, row_stab_err, max_out);
            end
            for (int r = 0; r <= rm1 && r < o_data.size() &&
                             r < rd_rows.size(); r++) begin
                n_chk++;
                if (rd_rows[r] !== e_rows[r] || o_data[r] !== e_data[r] ||
                    o_mask[r] !== e_mask[r] || o_last[r] !== e_last[r]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_row%0d read=%0d/%0d mask=%h/%h last=%b/%b",
                        t, r, rd_rows[r], e_rows[r], o_mask[r], e_mask[r],
                        o_last[r], e_last[r]);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_base_row  = '0;
        bus.req_rows_m1   = '0;
        bus.req_col_start = '0;
        bus.req_cols_m1   = '0;
        bus.sram_rd_gnt   = 1'b0;
        bus.out_ready     = 1'b0;
        test_reset();
        @(posedge CLK); #1;
        test_basic();
        @(posedge CLK); #1;
        test_wrap();
        @(posedge CLK); #1;
        test_align();
        @(posedge CLK); #1;
        test_backpressure();
        @(posedge CLK); #1;
        test_gnt_stall();
        @(posedge CLK); #1;
        test_reset_mid();
        @(posedge CLK); #1;
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/scpad_tile_reader.md
SCPAD_TILE_READER -- requirements
Module: scpad_tile_reader

Interface
REQ-001 Parameters SHALL be: NUM_COLS, default 32, lanes per row; ELEM_BITS, default 16, bits per fp16 element; ROW_IDX_WIDTH, default 14, row index bits; MAX_DIM_WIDTH, default 5, tile dimension bits.
REQ-002 Clock is one clock; reset is synchronous and active-high. Ports SHALL be: CLK input 1 clock; RST input 1 synchronous active-high reset.
REQ-003 req_valid input 1 tile request present; req_ready output 1 request accepted when both high.
REQ-004 req_base_row input ROW_IDX_WIDTH first row; req_rows_m1 input MAX_DIM_WIDTH tile rows minus 1.
REQ-005 req_col_start input MAX_DIM_WIDTH first column; req_cols_m1 input MAX_DIM_WIDTH tile columns minus 1.
REQ-006 sram_rd_req output 1 read request; sram_rd_gnt input 1 arbiter grant; sram_rd_row output ROW_IDX_WIDTH row read.
REQ-007 sram_rd_data input NUM_COLS*ELEM_BITS row data, valid exactly 1 cycle after a granted request.
REQ-008 out_valid output 1, out_ready input 1 row-stream handshake.
REQ-009 out_data output NUM_COLS*ELEM_BITS aligned row; out_mask output NUM_COLS lane-valid mask; out_last output 1 final tile row.
REQ-010 busy output 1 tile in progress; done output 1 single-cycle completion pulse.

Function
REQ-011 FSM SHALL have states IDLE, ISSUE, DRAIN; req_ready=1 only in IDLE.
REQ-012 IDLE: on req_valid, latch all req_* fields, clear row counter, go to ISSUE next cycle.
REQ-013 ISSUE: sram_rd_req=1 only when buffered rows plus in-flight reads < 2; sram_rd_row = (base_row + row counter) mod 2^ROW_IDX_WIDTH (wraps, no error).
REQ-014 A read is issued only in a cycle with sram_rd_req && sram_rd_gnt; the row counter increments only then; sram_rd_row SHALL hold stable while request is ungranted.
REQ-015 After the read for row counter == rows_m1 is granted, go to DRAIN.
REQ-016 Returned data SHALL enter a 2-entry FIFO the cycle after grant; the FIFO never overflows by REQ-013 credit rule.
REQ-017 Alignment: out_data lane i = stored row lane (col_start + i) mod NUM_COLS (rotate right by col_start elements).
REQ-018 out_mask bit i = 1 iff i <= cols_m1 and col_start + i <= NUM_COLS-1 (columns past lane 31 clipped, no wrap).
REQ-019 out_valid = FIFO non-empty; entry pops on out_valid && out_ready; out_data/mask/last stable while out_valid && !out_ready.
REQ-020 out_last = 1 on the row whose index equals rows_m1, tagged at issue.
REQ-021 DRAIN: when FIFO empty and nothing in flight, pulse done for 1 cycle and return to IDLE; new request accepted no earlier than the cycle after done.
REQ-022 busy = 1 in ISSUE and DRAIN.
REQ-023 Minimum latency with gnt and out_ready held high: request accept cycle T, first read T+1, first out_valid T+2, one row per cycle thereafter.
REQ-024 Simultaneous FIFO push and pop SHALL be allowed, keeping count unchanged.

Reset
REQ-025 RST high on CLK edge: FSM to IDLE, counters and FIFO cleared, in-flight data discarded; next cycle req_ready=1 and sram_rd_req, out_valid, out_last, busy, done = 0.
REQ-026 RST mid-tile SHALL drop the tile without done; data returning in the cycle after reset is ignored.

Verification
REQ-027 Base 100, rows_m1 3, col_start 0, cols_m1 31, gnt/ready high -> reads rows 100..103 on cycles T+1..T+4; 4 outputs with mask 0xFFFFFFFF, out_last on 4th, done at T+6.
REQ-028 Base 16382, rows_m1 3 -> sram_rd_row sequence 16382, 16383, 0, 1.
REQ-029 col_start 28, cols_m1 7 -> out_data lanes 0..3 = stored lanes 28..31, out_mask 0x0000000F.
REQ-030 out_ready low 10 cycles mid-tile -> at most 2 rows buffered, sram_rd_req low while full, no rows lost or duplicated, data held stable.
REQ-031 sram_rd_gnt low 3 cycles during ISSUE -> sram_rd_row stable, row counter frozen, output order unchanged.
REQ-032 RST asserted after 2 of 8 rows output -> next cycle idle outputs per REQ-025, no done; new request completes normally.
